// File: rtl/instruction_store.sv
// Writable program memory for the CPU fetch stage: registered fetch port, load port,
// per-word valid bitmap with filler readback, and a sequential checksum scan engine.
module instruction_store #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReadEnable,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oInstructionValid,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    output logic                  oWriteReject,
    input  logic                  iClear,
    input  logic                  iScan,
    output logic                  oBusy,
    output logic                  oScanDone,
    output logic [DATA_WIDTH-1:0] oChecksum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    scan_state_t           state_r;
    scan_state_t           state_s;
    logic [IDX_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] acc_r;
    logic                  busy_r;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] scan_word_s;
    logic                  rd_ok_s;
    logic                  wr_ok_s;
    logic                  wr_rej_s;
    logic                  clr_ok_s;

    // Addresses beyond the physical array alias nothing; they must never hit a low word.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    // Effective-word lookup and request qualification against busy / clear.
    always_comb begin
        rd_idx_s = iAddress[IDX_W-1:0];
        wr_idx_s = iWriteAddress[IDX_W-1:0];
        if (in_range(iAddress) && valid_r[rd_idx_s]) begin
            rd_word_s = mem_r[rd_idx_s];
        end else begin
            rd_word_s = DEFAULT_WORD;
        end
        if (valid_r[cnt_r]) begin
            scan_word_s = mem_r[cnt_r];
        end else begin
            scan_word_s = DEFAULT_WORD;
        end
        rd_ok_s  = iReadEnable && !busy_r;
        clr_ok_s = iClear && !busy_r;
        // A clear swallows a same-cycle write silently, so it never raises a reject.
        wr_ok_s  = iWriteEnable && !busy_r && !iClear && in_range(iWriteAddress);
        wr_rej_s = iWriteEnable && (busy_r || (!iClear && !in_range(iWriteAddress)));
    end

    // Storage array; deliberately left unreset.
    always_ff @(posedge Clock) begin
        if (wr_ok_s) begin
            mem_r[wr_idx_s] <= iWriteData;
        end
    end

    // Valid bitmap: clear wins over write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_r <= '0;
        end else if (clr_ok_s) begin
            valid_r <= '0;
        end else if (wr_ok_s) begin
            valid_r[wr_idx_s] <= 1'b1;
        end
    end

    // Fetch port and write-reject pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oInstruction      <= DEFAULT_WORD;
            oInstructionValid <= 1'b0;
            oWriteReject      <= 1'b0;
        end else begin
            oWriteReject <= wr_rej_s;
            if (rd_ok_s) begin
                oInstruction      <= rd_word_s;
                oInstructionValid <= 1'b1;
            end else begin
                oInstructionValid <= 1'b0;
            end
        end
    end

    // Scan FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Scan FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (iScan) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Scan datapath: counter, accumulator, result capture and busy flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            oChecksum <= '0;
            oScanDone <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            busy_r    <= (state_s != IDLE);
            oScanDone <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (iScan) begin
                        cnt_r <= '0;
                        acc_r <= '0;
                    end
                end
                SCAN: begin
                    acc_r <= acc_r + scan_word_s;
                    if (cnt_r == LAST_IDX) begin
                        cnt_r     <= '0;
                        oChecksum <= acc_r + scan_word_s;
                        oScanDone <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oBusy = busy_r;

endmodule
